// File: rtl/console_scheduler.sv
// Text console RAM scheduler: display fetches at cx%8==5 with
// absolute priority, host writes queued in a 4-deep FIFO.
module console_scheduler #(
    parameter int COLS     = 80,
    parameter int ROWS     = 30,
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic        clk_pixel,
    input  logic        reset_n,
    input  logic [9:0]  cx,
    input  logic [9:0]  cy,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [11:0] host_addr,
    input  logic [15:0] host_data,
    output logic [11:0] ram_addr,
    output logic        ram_we,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    output logic [7:0]  character,
    output logic [7:0]  attribute,
    output logic        host_oob
);

    localparam logic [9:0]  HA8   = 10'(H_ACTIVE - 8);
    localparam logic [9:0]  HT3   = 10'(H_TOTAL - 3);
    localparam logic [9:0]  VA    = 10'(V_ACTIVE);
    localparam logic [9:0]  VT1   = 10'(V_TOTAL - 1);
    localparam logic [11:0] C12   = 12'(COLS);
    localparam logic [11:0] CELLS = 12'(COLS * ROWS);

    logic [9:0]  ny;
    logic        in_line;
    logic        eol;
    logic        fetch;
    logic [11:0] fetch_addr;

    logic        accept;
    logic        oob_hit;
    logic        push;
    logic        pop;

    logic [27:0] mem_q [4];
    logic [1:0]  wp_q, wp_d;
    logic [1:0]  rp_q, rp_d;
    logic [2:0]  count_q, count_d;
    logic        ready_q;
    logic        oob_q, oob_d;

    logic        f1_q, f2_q;
    logic [11:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [15:0] wdata_q, wdata_d;
    logic [7:0]  char_q, char_d;
    logic [7:0]  attr_q, attr_d;

    // Fetch decision and target cell address for the coming character cell.
    always_comb begin
        ny = (cy == VT1) ? 10'd0 : cy + 10'd1;
        in_line = (cx < HA8) && (cy < VA);
        eol = (cx == HT3) && (ny < VA);
        fetch = (cx[2:0] == 3'd5) && (in_line || eol);
        if (in_line) begin
            fetch_addr = 12'(cy[9:4]) * C12 + 12'(cx[9:3]) + 12'd1;
        end else begin
            fetch_addr = 12'(ny[9:4]) * C12;
        end
    end

    // Host FIFO bookkeeping; writes drain only in cycles with no fetch.
    always_comb begin
        accept  = host_valid && ready_q;
        oob_hit = accept && (host_addr >= CELLS);
        push    = accept && !oob_hit;
        pop     = !fetch && (count_q != 3'd0);
        wp_d    = push ? wp_q + 2'd1 : wp_q;
        rp_d    = pop ? rp_q + 2'd1 : rp_q;
        count_d = count_q + {2'b00, push} - {2'b00, pop};
        oob_d   = oob_q || oob_hit;
    end

    // RAM port mux and character/attribute capture.
    always_comb begin
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        char_d  = char_q;
        attr_d  = attr_q;
        if (fetch) begin
            addr_d = fetch_addr;
        end else if (pop) begin
            we_d    = 1'b1;
            addr_d  = mem_q[rp_q][27:16];
            wdata_d = mem_q[rp_q][15:0];
        end
        if ((cx[2:0] == 3'd7) && f2_q) begin
            attr_d = ram_rdata[15:8];
            char_d = ram_rdata[7:0];
        end
    end

    // FIFO payload storage; needs no reset since count gates every read.
    always_ff @(posedge clk_pixel) begin
        if (push) begin
            mem_q[wp_q] <= {host_addr, host_data};
        end
    end

    // Control and output registers.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            wp_q    <= 2'd0;
            rp_q    <= 2'd0;
            count_q <= 3'd0;
            ready_q <= 1'b0;
            oob_q   <= 1'b0;
            f1_q    <= 1'b0;
            f2_q    <= 1'b0;
            addr_q  <= 12'd0;
            we_q    <= 1'b0;
            wdata_q <= 16'd0;
            char_q  <= 8'd0;
            attr_q  <= 8'd0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ready_q <= (count_d < 3'd4);
            oob_q   <= oob_d;
            f1_q    <= fetch;
            f2_q    <= f1_q;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            char_q  <= char_d;
            attr_q  <= attr_d;
        end
    end

    assign host_ready = ready_q;
    assign host_oob   = oob_q;
    assign ram_addr   = addr_q;
    assign ram_we     = we_q;
    assign ram_wdata  = wdata_q;
    assign character  = char_q;
    assign attribute  = attr_q;

endmodule

// File: tb/tb_console_scheduler.sv
// Directed bench for console_scheduler: fetch timing, FIFO
// ordering/backpressure, out-of-range drop and reset flush.
module tb_console_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  cx, cy;
    logic        host_valid;
    logic        host_ready;
    logic [11:0] host_addr;
    logic [15:0] host_data;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic [7:0]  character;
    logic [7:0]  attribute;
    logic        host_oob;

    int n_vec = 0;
    int n_err = 0;

    logic [11:0] ta [5];
    logic [15:0] td [5];

    console_scheduler dut (
        .clk_pixel  (clk),
        .reset_n    (reset_n),
        .cx         (cx),
        .cy         (cy),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_addr  (host_addr),
        .host_data  (host_data),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .character  (character),
        .attribute  (attribute),
        .host_oob   (host_oob)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " we"}, 32'(ram_we), 32'd0);
        chk({tag, " addr"}, 32'(ram_addr), 32'd0);
        chk({tag, " wdata"}, 32'(ram_wdata), 32'd0);
        chk({tag, " char"}, 32'(character), 32'd0);
        chk({tag, " attr"}, 32'(attribute), 32'd0);
        chk({tag, " oob"}, 32'(host_oob), 32'd0);
        chk({tag, " ready"}, 32'(host_ready), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        cx = 10'd0;
        cy = 10'd500;
        host_valid = 1'b0;
        host_addr = 12'd0;
        host_data = 16'd0;
        ram_rdata = 16'd0;
        #2;
        chk_zero("rst");
        step();
        step();
        chk("rst_hold ready", 32'(host_ready), 32'd0);
        reset_n = 1'b1;
        chk("pre_edge ready", 32'(host_ready), 32'd0);
        step();
        chk("post_rst ready", 32'(host_ready), 32'd1);

        // cx%8==7 with no read two cycles earlier: hold
        cx = 10'd7; cy = 10'd0; ram_rdata = 16'hFFFF;
        step();
        chk("noread char", 32'(character), 32'd0);

        cx = 10'd5; cy = 10'd0;
        step();
        chk("fetch0 addr", 32'(ram_addr), 32'd1);
        chk("fetch0 we", 32'(ram_we), 32'd0);
        cx = 10'd6;
        step();
        chk("cx6 we", 32'(ram_we), 32'd0);
        chk("cx6 addr", 32'(ram_addr), 32'd1);
        cx = 10'd7; ram_rdata = 16'h1E41;
        step();
        chk("load char", 32'(character), 32'h41);
        chk("load attr", 32'(attribute), 32'h1E);

        cx = 10'd797; cy = 10'd15;
        step();
        chk("eol addr", 32'(ram_addr), 32'd80);
        chk("eol we", 32'(ram_we), 32'd0);
        cx = 10'd798;
        step();
        cx = 10'd799; ram_rdata = 16'h2A33;
        step();
        chk("eol char", 32'(character), 32'h33);
        chk("eol attr", 32'(attribute), 32'h2A);

        cx = 10'd629; cy = 10'd0;
        step();
        chk("last cell addr", 32'(ram_addr), 32'd79);
        cx = 10'd637;
        step();
        chk("past active addr", 32'(ram_addr), 32'd79);
        chk("past active we", 32'(ram_we), 32'd0);

        cx = 10'd796; cy = 10'd479;
        host_valid = 1'b1; host_addr = 12'd7; host_data = 16'h1234;
        step();
        chk("push479 we", 32'(ram_we), 32'd0);
        chk("push479 addr", 32'(ram_addr), 32'd79);
        host_valid = 1'b0;
        cx = 10'd797;
        step();
        chk("pop479 we", 32'(ram_we), 32'd1);
        chk("pop479 addr", 32'(ram_addr), 32'd7);
        chk("pop479 wdata", 32'(ram_wdata), 32'h1234);

        cx = 10'd797; cy = 10'd524;
        step();
        chk("wrap addr", 32'(ram_addr), 32'd0);
        chk("wrap we", 32'(ram_we), 32'd0);

        // out-of-range write dropped, in-range neighbour accepted
        cx = 10'd100; cy = 10'd500;
        host_valid = 1'b1; host_addr = 12'd2400; host_data = 16'hBEEF;
        step();
        chk("oob flag", 32'(host_oob), 32'd1);
        chk("oob we", 32'(ram_we), 32'd0);
        host_addr = 12'd2399; host_data = 16'h0101;
        step();
        chk("oob dropped we", 32'(ram_we), 32'd0);
        host_valid = 1'b0;
        step();
        chk("2399 we", 32'(ram_we), 32'd1);
        chk("2399 addr", 32'(ram_addr), 32'd2399);
        chk("2399 wdata", 32'(ram_wdata), 32'h0101);
        chk("oob sticky", 32'(host_oob), 32'd1);

        // write pending during a fetch retires on the following edge
        cx = 10'd5; cy = 10'd0;
        host_valid = 1'b1; host_addr = 12'd300; host_data = 16'hA5A5;
        step();
        chk("f_prio we", 32'(ram_we), 32'd0);
        chk("f_prio addr", 32'(ram_addr), 32'd1);
        host_valid = 1'b0;
        cx = 10'd6;
        step();
        chk("cx6 pop we", 32'(ram_we), 32'd1);
        chk("cx6 pop addr", 32'(ram_addr), 32'd300);
        chk("cx6 pop wdata", 32'(ram_wdata), 32'hA5A5);

        // FIFO fills while fetches block every pop
        ta[0] = 12'd100; td[0] = 16'h1111;
        ta[1] = 12'd101; td[1] = 16'h2222;
        ta[2] = 12'd100; td[2] = 16'h3333;
        ta[3] = 12'd2399; td[3] = 16'h4444;
        ta[4] = 12'd555; td[4] = 16'h5555;
        cx = 10'd13; cy = 10'd32;
        for (int i = 0; i < 4; i++) begin
            host_valid = 1'b1; host_addr = ta[i]; host_data = td[i];
            step();
            chk("fill we", 32'(ram_we), 32'd0);
        end
        chk("full ready", 32'(host_ready), 32'd0);
        chk("full fetch addr", 32'(ram_addr), 32'd162);
        host_addr = ta[4]; host_data = td[4];
        step();
        chk("full ready hold", 32'(host_ready), 32'd0);
        chk("full we", 32'(ram_we), 32'd0);
        host_valid = 1'b0;
        cx = 10'd14;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain we", 32'(ram_we), 32'd1);
            chk("drain addr", 32'(ram_addr), 32'(ta[i]));
            chk("drain wdata", 32'(ram_wdata), 32'(td[i]));
            chk("drain ready", 32'(host_ready), 32'd1);
        end
        step();
        chk("drained we", 32'(ram_we), 32'd0);

        // back-to-back pushes in blanking retire on consecutive edges
        cx = 10'd100; cy = 10'd500;
        for (int i = 0; i < 5; i++) begin
            ta[i] = 12'(10 + i); td[i] = 16'(16'hC000 + i);
        end
        for (int i = 0; i < 5; i++) begin
            host_valid = 1'b1; host_addr = ta[i]; host_data = td[i];
            step();
            chk("b2b ready", 32'(host_ready), 32'd1);
            if (i > 0) begin
                chk("b2b we", 32'(ram_we), 32'd1);
                chk("b2b addr", 32'(ram_addr), 32'(ta[i-1]));
                chk("b2b wdata", 32'(ram_wdata), 32'(td[i-1]));
            end
        end
        host_valid = 1'b0;
        step();
        chk("b2b last addr", 32'(ram_addr), 32'(ta[4]));
        chk("b2b last wdata", 32'(ram_wdata), 32'(td[4]));
        step();
        chk("b2b idle we", 32'(ram_we), 32'd0);

        // reset with queued writes flushes them
        cx = 10'd13; cy = 10'd32;
        for (int i = 0; i < 3; i++) begin
            host_valid = 1'b1;
            host_addr = 12'(200 + i); host_data = 16'(16'hD000 + i);
            step();
        end
        host_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("midrst");
        step();
        reset_n = 1'b1;
        cx = 10'd100; cy = 10'd500;
        step();
        chk("rel ready", 32'(host_ready), 32'd1);
        chk("rel we0", 32'(ram_we), 32'd0);
        step();
        chk("rel we1", 32'(ram_we), 32'd0);
        step();
        chk("rel we2", 32'(ram_we), 32'd0);
        chk("rel oob", 32'(host_oob), 32'd0);
        host_valid = 1'b1; host_addr = 12'd42; host_data = 16'h4242;
        step();
        chk("new push we", 32'(ram_we), 32'd0);
        host_valid = 1'b0;
        step();
        chk("new pop we", 32'(ram_we), 32'd1);
        chk("new pop addr", 32'(ram_addr), 32'd42);
        chk("new pop wdata", 32'(ram_wdata), 32'h4242);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/console_scheduler.md
CONSOLE_SCHEDULER -- requirements
Module: console_scheduler

Interface
REQ-001 Parameter COLS, default 80, text columns per row (8-pixel cells).
REQ-002 Parameter ROWS, default 30, text rows (16-line cells).
REQ-003 Parameter H_ACTIVE / H_TOTAL, default 640 / 800, active and total pixels per line.
REQ-004 Parameter V_ACTIVE / V_TOTAL, default 480 / 525, active and total lines per frame.
REQ-005 clk_pixel  in  1  pixel clock; the only clock.
REQ-006 reset_n  in  1  reset, asynchronous, active-low.
REQ-007 cx  in  10  current pixel column, 0..H_TOTAL-1.
REQ-008 cy  in  10  current line, 0..V_TOTAL-1.
REQ-009 host_valid  in  1  host write request.
REQ-010 host_ready  out  1  host write accepted when valid && ready.
REQ-011 host_addr  in  12  cell index, row*COLS+col.
REQ-012 host_data  in  16  {attribute[15:8], character[7:0]}.
REQ-013 ram_addr  out  12  text RAM address, registered.
REQ-014 ram_we  out  1  text RAM write strobe, registered.
REQ-015 ram_wdata  out  16  text RAM write data, registered.
REQ-016 ram_rdata  in  16  text RAM read data; valid the cycle after ram_addr is presented.
REQ-017 character  out  8  character code for the console datapath.
REQ-018 attribute  out  8  attribute byte for the console datapath.
REQ-019 host_oob  out  1  sticky flag: out-of-range host write dropped.

Function
REQ-020 The fetch condition F SHALL be true in a cycle where cx[2:0]==5 and either cx<H_ACTIVE-8 and cy<V_ACTIVE (target cell (cx>>3)+1, row cy>>4), or cx==H_TOTAL-3 and ny<V_ACTIVE, where ny=(cy+1) mod V_TOTAL (target cell 0, row ny>>4).
REQ-021 On the edge ending an F cycle, the block SHALL register ram_addr=row*COLS+col, ram_we=0; display reads have absolute priority over host writes.
REQ-022 On the edge ending a cycle where cx[2:0]==7 and the preceding F cycle (cx-2) issued a read, {attribute,character} SHALL load ram_rdata; otherwise they hold.
REQ-023 Net display latency: data addressed at cx[2:0]==5 SHALL be on character/attribute from the first pixel (cx[2:0]==0) of the target cell.
REQ-024 Host writes SHALL pass through a 4-entry FIFO; host_ready = (count<4), registered from FIFO count.
REQ-025 Push on host_valid && host_ready; host_addr >= COLS*ROWS SHALL be dropped without entering the FIFO and SHALL set host_oob until reset.
REQ-026 Pop SHALL occur on any edge ending a non-F cycle with FIFO non-empty: register ram_we=1, ram_addr/ram_wdata from FIFO head.
REQ-027 A cycle with neither F nor a pop SHALL register ram_we=0; ram_addr and ram_wdata hold.
REQ-028 Simultaneous push and pop SHALL leave count unchanged, including at count 4 only if a pop frees the slot in the same edge (ready already low, so no push at 4).
REQ-029 FIFO order SHALL be strict first-in first-out; writes to the same address retire in acceptance order.
REQ-030 Address arithmetic SHALL be 12-bit unsigned; row*COLS+col SHALL not exceed COLS*ROWS-1 for legal cx/cy.
REQ-031 A host write to the cell being fetched in the same window SHALL be observed by the display no earlier than the next fetch of that cell.

Reset
REQ-032 While reset_n is low: ram_we=0, ram_addr=0, ram_wdata=0, character=0, attribute=0, host_oob=0, FIFO empty, host_ready=0.
REQ-033 host_ready SHALL rise on the first edge after reset_n deasserts; reset mid-operation SHALL discard queued writes without any ram_we pulse.

Verification
REQ-034 cx=5,cy=0 -> next cycle ram_addr=1, ram_we=0; ram_rdata=16'h1E41 at cx=7 -> character=8'h41, attribute=8'h1E at cx=8.
REQ-035 cx=797,cy=15 -> ram_addr=80 (row 1, cell 0); cx=797,cy=479 -> no read, FIFO pop permitted.
REQ-036 Push 5 writes back-to-back during vertical blanking -> host_ready low after 4th accepted only if no pops occurred; all retire in order on consecutive edges.
REQ-037 host_valid with host_data pending while cx[2:0]==5 in active video -> write retires at cx[2:0]==6 edge, never in an F cycle.
REQ-038 host_addr=2400 -> not written, host_oob=1, remains 1 until reset_n low.
REQ-039 Assert reset_n low with 3 queued writes -> all outputs zero immediately; after release, no ram_we pulse until a new write is pushed.
